// File: rtl/free_list_ctrl.sv
// Physical-register free list for a 4-wide rename stage: up to 4 allocations and
// 4 releases per cycle over a circular list, with one-cycle flush recovery.
module free_list_ctrl #(
  parameter int PR_NUM   = 128,
  parameter int AR_NUM   = 32,
  parameter int FL_DEPTH = PR_NUM - AR_NUM,
  localparam int PR_W    = $clog2(PR_NUM),
  localparam int CNT_W   = $clog2(FL_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic             inst0_dest_en,
  input  logic             inst1_dest_en,
  input  logic             inst2_dest_en,
  input  logic             inst3_dest_en,
  output logic             alloc_ready,
  output logic [PR_W-1:0]  inst0_alloc_PR,
  output logic [PR_W-1:0]  inst1_alloc_PR,
  output logic [PR_W-1:0]  inst2_alloc_PR,
  output logic [PR_W-1:0]  inst3_alloc_PR,
  input  logic             retire0_dest_en,
  input  logic             retire1_dest_en,
  input  logic             retire2_dest_en,
  input  logic             retire3_dest_en,
  input  logic [PR_W-1:0]  retire0_old_PR,
  input  logic [PR_W-1:0]  retire1_old_PR,
  input  logic [PR_W-1:0]  retire2_old_PR,
  input  logic [PR_W-1:0]  retire3_old_PR,
  input  logic             flush,
  output logic [CNT_W-1:0] free_count
);

  localparam int PTR_W = $clog2(FL_DEPTH);

  logic [PR_W-1:0]  fl_q [FL_DEPTH];
  logic [PR_W-1:0]  fl_d [FL_DEPTH];
  logic [PTR_W-1:0] spec_head_q, spec_head_d;
  logic [PTR_W-1:0] commit_head_q, commit_head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] free_count_q, free_count_d;

  logic [3:0]       dest_en;
  logic [3:0]       ret_en;
  logic [PR_W-1:0]  ret_pr [4];
  logic [PR_W-1:0]  alloc_pr [4];
  logic [PTR_W-1:0] alloc_idx [4];
  logic [PTR_W-1:0] rel_idx [4];
  logic [2:0]       a_n;
  logic [2:0]       r_n;
  logic             alloc_fire;

  // Circular increment by 0..4 for a non-power-of-two depth.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [2:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(FL_DEPTH)) s = s - (PTR_W+1)'(FL_DEPTH);
    return s[PTR_W-1:0];
  endfunction

  assign dest_en   = {inst3_dest_en, inst2_dest_en, inst1_dest_en, inst0_dest_en};
  assign ret_en    = {retire3_dest_en, retire2_dest_en, retire1_dest_en, retire0_dest_en};
  assign ret_pr[0] = retire0_old_PR;
  assign ret_pr[1] = retire1_old_PR;
  assign ret_pr[2] = retire2_old_PR;
  assign ret_pr[3] = retire3_old_PR;

  // Allocation side: requesting slots are packed onto consecutive list entries.
  always_comb begin
    a_n = '0;
    for (int i = 0; i < 4; i++) begin
      alloc_idx[i] = ptr_add(spec_head_q, a_n);
      alloc_pr[i]  = dest_en[i] ? fl_q[alloc_idx[i]] : '0;
      a_n          = a_n + 3'(dest_en[i]);
    end
  end

  assign alloc_ready    = (free_count_q >= CNT_W'(a_n));
  assign alloc_fire     = alloc_valid & alloc_ready & ~flush;
  assign inst0_alloc_PR = alloc_pr[0];
  assign inst1_alloc_PR = alloc_pr[1];
  assign inst2_alloc_PR = alloc_pr[2];
  assign inst3_alloc_PR = alloc_pr[3];
  assign free_count     = free_count_q;

  // Release side: returned PRs are written behind the tail in slot order.
  always_comb begin
    fl_d = fl_q;
    r_n  = '0;
    for (int i = 0; i < 4; i++) begin
      rel_idx[i] = ptr_add(tail_q, r_n);
      if (ret_en[i]) fl_d[rel_idx[i]] = ret_pr[i];
      r_n = r_n + 3'(ret_en[i]);
    end
  end

  always_comb begin
    commit_head_d = ptr_add(commit_head_q, r_n);
    tail_d        = ptr_add(tail_q, r_n);
    spec_head_d   = spec_head_q;
    free_count_d  = free_count_q + CNT_W'(r_n);
    if (flush) begin
      // Rewinding to the committed point reclaims every speculative allocation.
      spec_head_d  = commit_head_d;
      free_count_d = CNT_W'(FL_DEPTH);
    end else if (alloc_fire) begin
      spec_head_d  = ptr_add(spec_head_q, a_n);
      free_count_d = free_count_q - CNT_W'(a_n) + CNT_W'(r_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) fl_q[i] <= PR_W'(AR_NUM + i);
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
      free_count_q  <= CNT_W'(FL_DEPTH);
    end else begin
      fl_q          <= fl_d;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      free_count_q  <= free_count_d;
    end
  end

`ifndef SYNTHESIS
  // Only PRs handed out and not yet committed may come back; the count stays bounded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (free_count_q <= CNT_W'(FL_DEPTH));
      assert (CNT_W'(r_n) <= CNT_W'(FL_DEPTH) - free_count_q);
    end
  end
`endif

endmodule

// File: tb/tb_free_list_ctrl.sv
// Bench for free_list_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based free-list / ROB model.
module tb_free_list_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] en = '0;
  logic [3:0] ren = '0;
  logic [6:0] old [4];
  logic       flush = 1'b0;
  logic       rdy_o;
  logic [6:0] pr_o [4];
  logic [6:0] fc_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  free_list_ctrl dut (
    .clk(clk), .rst(rst), .alloc_valid(valid),
    .inst0_dest_en(en[0]), .inst1_dest_en(en[1]), .inst2_dest_en(en[2]), .inst3_dest_en(en[3]),
    .alloc_ready(rdy_o),
    .inst0_alloc_PR(pr_o[0]), .inst1_alloc_PR(pr_o[1]), .inst2_alloc_PR(pr_o[2]), .inst3_alloc_PR(pr_o[3]),
    .retire0_dest_en(ren[0]), .retire1_dest_en(ren[1]), .retire2_dest_en(ren[2]), .retire3_dest_en(ren[3]),
    .retire0_old_PR(old[0]), .retire1_old_PR(old[1]), .retire2_old_PR(old[2]), .retire3_old_PR(old[3]),
    .flush(flush), .free_count(fc_o)
  );

  typedef struct packed {
    logic            rst;
    logic            valid;
    logic [3:0]      en;
    logic [3:0]      ren;
    logic            flush;
    logic            chk;
    logic            rdy;
    logic [3:0][6:0] pr;
    logic [6:0]      fc;
  } vec_t;

  typedef struct {
    int ar;
    int npr;
    int opr;
  } rob_t;

  vec_t tbl [14];
  int   free_q [$];
  rob_t rob_q [$];
  int   rel_q [$];
  int   rat [32];
  int   crat [32];
  bit   busy [128];

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] e, input logic [3:0] re,
                              input logic f, input logic c, input logic rd,
                              input int p0, input int p1, input int p2, input int p3, input int fc);
    vec_t t;
    t.rst = r; t.valid = v; t.en = e; t.ren = re; t.flush = f; t.chk = c; t.rdy = rd;
    t.pr[0] = 7'(p0); t.pr[1] = 7'(p1); t.pr[2] = 7'(p2); t.pr[3] = 7'(p3); t.fc = 7'(fc);
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid = 1'b0; en = '0; ren = '0; flush = 1'b0;
    for (int i = 0; i < 4; i++) old[i] = 7'(i + 1);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic model_init();
    free_q.delete(); rob_q.delete();
    for (int i = 32; i < 128; i++) free_q.push_back(i);
    for (int i = 0; i < 32; i++) begin rat[i] = i; crat[i] = i; end
    for (int i = 0; i < 128; i++) busy[i] = (i < 32);
  endtask

  initial begin
    int an, efc, k, nr;
    bit erdy;
    logic [3:0] m;
    rob_t r;

    idle_inputs();
    @(negedge clk);

    tbl[0]  = mk(1, 0, 4'b0000, 4'b0000, 0, 0, 0,  0,  0,  0,  0,  0);
    tbl[1]  = mk(0, 1, 4'b1111, 4'b0000, 0, 1, 1, 32, 33, 34, 35, 96);
    tbl[2]  = mk(0, 0, 4'b0000, 4'b0000, 0, 1, 1,  0,  0,  0,  0, 92);
    tbl[3]  = mk(1, 0, 4'b0000, 4'b0000, 0, 0, 0,  0,  0,  0,  0,  0);
    tbl[4]  = mk(0, 1, 4'b1010, 4'b0000, 0, 1, 1,  0, 32,  0, 33, 96);
    tbl[5]  = mk(0, 0, 4'b0000, 4'b0000, 0, 1, 1,  0,  0,  0,  0, 94);
    tbl[6]  = mk(1, 0, 4'b0000, 4'b0000, 0, 0, 0,  0,  0,  0,  0,  0);
    tbl[7]  = mk(0, 1, 4'b1111, 4'b0000, 0, 1, 1, 32, 33, 34, 35, 96);
    tbl[8]  = mk(0, 1, 4'b1111, 4'b0000, 0, 1, 1, 36, 37, 38, 39, 92);
    tbl[9]  = mk(0, 1, 4'b0011, 4'b0000, 0, 1, 1, 40, 41,  0,  0, 88);
    tbl[10] = mk(0, 0, 4'b0000, 4'b0111, 0, 1, 1,  0,  0,  0,  0, 86);
    tbl[11] = mk(0, 0, 4'b0000, 4'b0000, 1, 1, 1,  0,  0,  0,  0, 89);
    tbl[12] = mk(0, 1, 4'b0001, 4'b0000, 0, 1, 1, 35,  0,  0,  0, 96);
    tbl[13] = mk(0, 0, 4'b0000, 4'b0000, 0, 1, 1,  0,  0,  0,  0, 95);

    for (int v = 0; v < 14; v++) begin
      rst = tbl[v].rst; valid = tbl[v].valid; en = tbl[v].en; ren = tbl[v].ren; flush = tbl[v].flush;
      for (int i = 0; i < 4; i++) old[i] = 7'(i + 1);
      #1;
      if (tbl[v].chk) begin
        check($sformatf("vec%0d_ready", v), int'(rdy_o), int'(tbl[v].rdy));
        check($sformatf("vec%0d_free_count", v), int'(fc_o), int'(tbl[v].fc));
        for (int i = 0; i < 4; i++)
          check($sformatf("vec%0d_pr%0d", v, i), int'(pr_o[i]), int'(tbl[v].pr[i]));
      end
      tick();
    end

    // Drain to the wrap point: released PRs 1,2,3 sit at fl[0..2].
    idle_inputs();
    valid = 1'b1; en = 4'b1111;
    for (int c = 0; c < 23; c++) begin
      #1;
      check("wrap_fc", int'(fc_o), 95 - 4 * c);
      for (int i = 0; i < 4; i++) check("wrap_pr", int'(pr_o[i]), 36 + 4 * c + i);
      tick();
    end
    en = 4'b0111;
    #1;
    check("wrap_ready", int'(rdy_o), 1);
    check("wrap_old0", int'(pr_o[0]), 1);
    check("wrap_old1", int'(pr_o[1]), 2);
    check("wrap_old2", int'(pr_o[2]), 3);
    tick();
    idle_inputs();
    #1;
    check("wrap_empty_fc", int'(fc_o), 0);

    // Exhaust the list with 24 full groups.
    do_reset();
    valid = 1'b1; en = 4'b1111;
    for (int c = 0; c < 24; c++) tick();
    #1;
    check("empty_fc", int'(fc_o), 0);
    check("empty_ready4", int'(rdy_o), 0);
    en = 4'b0001;
    #1;
    check("empty_ready1", int'(rdy_o), 0);
    tick();
    #1;
    check("stall_fc", int'(fc_o), 0);

    // Two free, ask for three while two come back: stall, then go.
    do_reset();
    valid = 1'b1; en = 4'b1111;
    for (int c = 0; c < 23; c++) tick();
    en = 4'b0011;
    tick();
    en = 4'b0111; ren = 4'b0011;
    #1;
    check("short_fc", int'(fc_o), 2);
    check("short_ready", int'(rdy_o), 0);
    tick();
    ren = 4'b0000;
    #1;
    check("refill_fc", int'(fc_o), 4);
    check("refill_ready", int'(rdy_o), 1);
    check("refill_pr0", int'(pr_o[0]), 126);
    check("refill_pr1", int'(pr_o[1]), 127);
    check("refill_pr2", int'(pr_o[2]), 1);
    check("refill_pr3", int'(pr_o[3]), 0);
    tick();
    #1;
    check("refill_after_fc", int'(fc_o), 1);

    // Reset wins over alloc, release and flush in the same cycle.
    rst = 1'b1; valid = 1'b1; en = 4'b1111; ren = 4'b0001; flush = 1'b1;
    tick();
    rst = 1'b0; ren = '0; flush = 1'b0;
    #1;
    check("rst_mid_fc", int'(fc_o), 96);
    for (int i = 0; i < 4; i++) check("rst_mid_pr", int'(pr_o[i]), 32 + i);

    // Randomized traffic against the reference model.
    do_reset();
    model_init();
    for (int c = 0; c < 1200; c++) begin
      valid = ($urandom_range(3) != 0);
      en    = 4'($urandom);
      flush = ($urandom_range(63) == 0);
      m     = ((c / 150) % 2 == 1) ? 4'($urandom) : 4'($urandom & $urandom & $urandom);
      ren   = '0;
      nr    = 0;
      for (int i = 0; i < 4; i++) begin
        if (m[i] && nr < rob_q.size()) begin
          ren[i] = 1'b1; old[i] = 7'(rob_q[nr].opr); nr++;
        end else begin
          old[i] = 7'($urandom);
        end
      end
      #1;
      an   = $countones(en);
      efc  = free_q.size();
      erdy = (efc >= an);
      check("rand_fc", int'(fc_o), efc);
      check("rand_ready", int'(rdy_o), int'(erdy));
      k = 0;
      for (int i = 0; i < 4; i++) begin
        if (!en[i]) check("rand_pr_idle", int'(pr_o[i]), 0);
        else begin
          if (erdy) check("rand_pr", int'(pr_o[i]), free_q[k]);
          k++;
        end
      end

      rel_q.delete();
      for (int i = 0; i < nr; i++) begin
        r = rob_q.pop_front();
        rel_q.push_back(r.opr);
        crat[r.ar] = r.npr;
        busy[r.opr] = 1'b0;
      end
      if (flush) begin
        for (int i = rob_q.size() - 1; i >= 0; i--) begin
          free_q.push_front(rob_q[i].npr);
          busy[rob_q[i].npr] = 1'b0;
        end
        rob_q.delete();
        for (int i = 0; i < 32; i++) rat[i] = crat[i];
      end else if (valid && erdy) begin
        for (int i = 0; i < 4; i++) begin
          if (en[i]) begin
            check("rand_dup", int'(busy[pr_o[i]]), 0);
            r.npr = free_q.pop_front();
            busy[r.npr] = 1'b1;
            r.ar  = $urandom_range(31, 1);
            r.opr = rat[r.ar];
            rat[r.ar] = r.npr;
            rob_q.push_back(r);
          end
        end
      end
      foreach (rel_q[i]) free_q.push_back(rel_q[i]);
      tick();
    end
    idle_inputs();
    #1;
    check("rand_final_fc", int'(fc_o), free_q.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
